// File: rtl/regfile_pkg.sv
// Shared constants and port-state encoding for the two-port register file read unit.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_e;
endpackage

// File: rtl/reg_read_port.sv
// One read port: req/gnt handshake, registered one-cycle-latency data, write-through bypass.
module reg_read_port #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              gnt,
  output logic              valid,
  output logic [DATA_W-1:0] data
);
  import regfile_pkg::*;

  port_state_e       state;
  logic [DATA_W-1:0] rval;
  logic              accept;

  assign valid  = (state == FULL);
  assign gnt    = !valid || ready;
  assign accept = req && gnt;

  // A same-edge write to the addressed register wins over the stale array value.
  always_comb begin
    rval = mem_rdata;
    if (addr == '0)                         rval = '0;
    else if (wr_en && (wr_addr == addr))    rval = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      data  <= '0;
    end else if (accept) begin
      state <= FULL;
      data  <= rval;
    end else if (ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: rtl/regfile_read_unit.sv
// 32x32 register file storage with write port and two independent handshaked read ports.
module regfile_read_unit #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ra_req,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic              ra_gnt,
  output logic              ra_valid,
  output logic [DATA_W-1:0] ra_data,
  input  logic              ra_ready,
  input  logic              rb_req,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic              rb_gnt,
  output logic              rb_valid,
  output logic [DATA_W-1:0] rb_data,
  input  logic              rb_ready
);
  import regfile_pkg::REG_ZERO;

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != REG_ZERO)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .clk(clk), .rst(rst), .req(ra_req), .addr(ra_addr), .ready(ra_ready),
    .mem_rdata(mem[ra_addr]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(ra_gnt), .valid(ra_valid), .data(ra_data)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .clk(clk), .rst(rst), .req(rb_req), .addr(rb_addr), .ready(rb_ready),
    .mem_rdata(mem[rb_addr]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(rb_gnt), .valid(rb_valid), .data(rb_data)
  );
endmodule

// File: doc/regfile_read_unit.md
# regfile_read_unit

Two-port read side of the 32 x 32-bit register file. It holds the register storage and accepts writes from the write port. It serves two independent read ports, each with a request/ready handshake and a registered, one-cycle-latency output. The unit sits between the register bank's write path and the consumers, such as operand fetch and a debug/scan reader.

## Interface
Parameters:
- DATA_W, 32, register width
- NUM_REGS, 32, number of registers
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low; sampled on rising edge of clk
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  register written
- wr_data  in  DATA_W  write data
- ra_req  in  1  port A read request
- ra_addr  in  ADDR_W  port A read address
- ra_gnt  out  1  port A accepts a request this cycle (combinational)
- ra_valid  out  1  port A output data valid
- ra_data  out  DATA_W  port A read data
- ra_ready  in  1  port A consumer takes ra_data this cycle
- rb_req, rb_addr, rb_gnt, rb_valid, rb_data, rb_ready: same as port A, for port B

## Operation
- Storage: NUM_REGS x DATA_W. Register 0 is hardwired zero. Writes to address 0 are dropped, and reads of address 0 return 0.
- Write: when wr_en=1 on a clock edge, mem[wr_addr] <= wr_data (addr != 0).
- Each read port is an independent two-state machine:
  - EMPTY: valid=0.
  - FULL: valid=1, and data is held stable.
- Grant:
  - x_gnt = !x_valid | x_ready.
  - A request is accepted on an edge when x_req & x_gnt.
- EMPTY transitions:
  - Accepted request -> FULL. x_data loads the read value.
  - No request -> stay EMPTY.
- FULL transitions:
  - x_ready=1 and an accepted request -> stay FULL with new data (back-to-back, one result per cycle).
  - x_ready=1 and no request -> EMPTY.
  - x_ready=0 -> hold. x_data does not change and no request is accepted.
- Read value is sampled at accept time:
  - If wr_en & (wr_addr == x_addr) & (x_addr != 0) on the same edge, the value is wr_data (write-through bypass).
  - Otherwise it is mem[x_addr].
- Snapshot rule: data held in FULL is never refreshed by later writes to the same register.
- Ports A and B never interact. Both may read the same address in the same cycle, and both receive identical data.
- x_data while valid=0: holds its last value (don't-care for consumers; the bench does not check it).

## Timing
- Reset (rst=0 at an edge), with priority over all other inputs:
  - All mem entries become 0.
  - ra_valid = rb_valid = 0.
  - ra_data = rb_data = 0.
  - ra_gnt = rb_gnt = 1 after reset.
- Reset mid-operation: held outputs are discarded and valid drops on that edge. A write or request presented in the reset cycle is ignored.
- Read latency: request accepted at edge N -> x_valid=1 with data from edge N+1 until consumed.
- Throughput: 1 read per port per cycle while x_ready=1.
- Write-to-read: a write at edge N is visible to a request accepted at edge N (bypass) and later.
- x_gnt depends combinationally on x_ready and the x_valid register only. There is no path from x_req or x_addr to x_gnt.

## Structure
- Shared package `regfile_pkg`:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32, REG_ZERO=0
  - port-state encoding EMPTY/FULL
- Sub-module `reg_read_port`, instantiated twice, contains:
  - the handshake FSM
  - the output data register
  - the bypass compare
- Storage array and write logic live in the top, `regfile_read_unit`.

## Test plan
- Reset then read all 32 addresses on port A with ra_ready=1 -> every ra_data = 0; ra_valid is high one cycle after each accept.
- Write 0xDEADBEEF to r5, then request r5 on port A with ra_ready=1 -> ra_data=0xDEADBEEF the next cycle. Write 0x12345678 to r0, then read r0 -> 0.
- Same edge: wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, and ra_req to r7 -> ra_data=0xA5A5A5A5 (bypass); port B reading r7 on the same edge also gets 0xA5A5A5A5.
- Port A reads r3=0x11 with ra_ready=0 for 4 cycles while r3 is rewritten to 0x22 -> ra_gnt=0, ra_data stays 0x11. Raise ra_ready -> next request to r3 returns 0x22.
- Back-to-back requests r1, r2, r3 with r1=1, r2=2, r3=3 and ready=1 on both ports -> data 1, 2, 3 on consecutive cycles, valid continuously high.
- Port B FULL and stalled, then rst=0 for one cycle with wr_en=1 to r9 -> rb_valid=0, rb_data=0, r9 reads 0 afterwards.
